// File: rtl/gesummv_if.sv
`default_nettype none
// ============================================================================
// gesummv_if : memory-side port bundle of the GESUMMV engine
//   (A/B/x read ports with 1-cycle latency, tmp/y write ports).
// Revision   : 1.0
// ============================================================================
interface gesummv_if #(
    parameter int WIDTH = 32,
    parameter int IW    = 3,
    parameter int KW    = 6
);
    logic [IW-1:0]    v2_addr;
    logic             v2_wr_en;
    logic [WIDTH-1:0] v2_wr_data;
    logic [KW-1:0]    v3_addr;
    logic             v3_rd_en;
    logic [WIDTH-1:0] v3_rd_data;
    logic [KW-1:0]    v4_addr;
    logic             v4_rd_en;
    logic [WIDTH-1:0] v4_rd_data;
    logic [IW-1:0]    v5_addr;
    logic             v5_rd_en;
    logic [WIDTH-1:0] v5_rd_data;
    logic [IW-1:0]    v6_addr;
    logic             v6_wr_en;
    logic [WIDTH-1:0] v6_wr_data;

    modport master (
        output v2_addr, v2_wr_en, v2_wr_data,
        output v3_addr, v3_rd_en, input v3_rd_data,
        output v4_addr, v4_rd_en, input v4_rd_data,
        output v5_addr, v5_rd_en, input v5_rd_data,
        output v6_addr, v6_wr_en, v6_wr_data
    );

    modport slave (
        input  v2_addr, v2_wr_en, v2_wr_data,
        input  v3_addr, v3_rd_en, output v3_rd_data,
        input  v4_addr, v4_rd_en, output v4_rd_data,
        input  v5_addr, v5_rd_en, output v5_rd_data,
        input  v6_addr, v6_wr_en, v6_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/gesummv_engine.sv
`default_nettype none
// ============================================================================
// gesummv_engine : fixed-size GESUMMV, tmp = A*x, y = alpha*A*x + beta*B*x.
//   Optional busy/done status outputs under macro GESUMMV_STATUS_EN.
// Revision       : 1.0
// ============================================================================
module gesummv_engine #(
    parameter int N     = 8,
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             tstart,
    input  wire logic [WIDTH-1:0] v0,
    input  wire logic [WIDTH-1:0] v1,
    gesummv_if.master             mem
`ifdef GESUMMV_STATUS_EN
    ,
    output logic                  busy,
    output logic                  done
`endif
);
    localparam int IW = $clog2(N);
    localparam int KW = $clog2(N * N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACC   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [IW-1:0]    i, j;
    logic [WIDTH-1:0] ta, ya;
    logic [WIDTH-1:0] prod_a, prod_b, y_out;
    logic             last_i, last_j;

    assign last_i = (i == IW'(N - 1));
    assign last_j = (j == IW'(N - 1));
    // Read data arriving now belongs to the element issued one cycle earlier.
    assign prod_a = mem.v3_rd_data * mem.v5_rd_data;
    assign prod_b = mem.v4_rd_data * mem.v5_rd_data;
    assign y_out  = (v0 * ta) + (v1 * ya);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            ta    <= '0;
            ya    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (tstart) begin
                        i  <= '0;
                        j  <= '0;
                        ta <= '0;
                        ya <= '0;
                    end
                end
                ISSUE: begin
                    j <= j + IW'(1);
                    if (j != '0) begin
                        ta <= ta + prod_a;
                        ya <= ya + prod_b;
                    end
                end
                ACC: begin
                    ta <= ta + prod_a;
                    ya <= ya + prod_b;
                end
                WRITE: begin
                    if (!last_i) begin
                        i  <= i + IW'(1);
                        j  <= '0;
                        ta <= '0;
                        ya <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx       = state;
        mem.v2_addr    = '0;
        mem.v2_wr_en   = 1'b0;
        mem.v2_wr_data = '0;
        mem.v3_addr    = '0;
        mem.v3_rd_en   = 1'b0;
        mem.v4_addr    = '0;
        mem.v4_rd_en   = 1'b0;
        mem.v5_addr    = '0;
        mem.v5_rd_en   = 1'b0;
        mem.v6_addr    = '0;
        mem.v6_wr_en   = 1'b0;
        mem.v6_wr_data = '0;
        case (state)
            IDLE: begin
                if (tstart) state_nx = ISSUE;
            end
            ISSUE: begin
                mem.v3_rd_en = 1'b1;
                mem.v4_rd_en = 1'b1;
                mem.v5_rd_en = 1'b1;
                mem.v3_addr  = KW'(i * N + j);
                mem.v4_addr  = KW'(i * N + j);
                mem.v5_addr  = j;
                if (last_j) state_nx = ACC;
            end
            ACC: begin
                state_nx = WRITE;
            end
            WRITE: begin
                mem.v2_wr_en   = 1'b1;
                mem.v6_wr_en   = 1'b1;
                mem.v2_addr    = i;
                mem.v6_addr    = i;
                mem.v2_wr_data = ta;
                mem.v6_wr_data = y_out;
                state_nx       = last_i ? IDLE : ISSUE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef GESUMMV_STATUS_EN
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) done <= 1'b0;
        else     done <= (state == WRITE) && last_i;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_gesummv_engine.sv
`default_nettype none
// ============================================================================
// tb_gesummv_engine : table-driven bench for gesummv_engine (full runs per
//   record) plus hand-written reset-state and mid-run-reset sequences.
// Revision          : 1.0
// ============================================================================
module tb_gesummv_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        tstart;
    logic [31:0] v0, v1;
`ifdef GESUMMV_STATUS_EN
    logic        busy, done;
`endif

    gesummv_if #(.WIDTH(32), .IW(3), .KW(6)) mem ();

    gesummv_engine #(.N(8), .WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .tstart (tstart),
        .v0     (v0),
        .v1     (v1),
        .mem    (mem)
`ifdef GESUMMV_STATUS_EN
        ,
        .busy   (busy),
        .done   (done)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] amem [64];
    logic [31:0] bmem [64];
    logic [31:0] xmem [8];

    always @(posedge clk) begin
        if (mem.v3_rd_en) mem.v3_rd_data <= amem[mem.v3_addr];
        if (mem.v4_rd_en) mem.v4_rd_data <= bmem[mem.v4_addr];
        if (mem.v5_rd_en) mem.v5_rd_data <= xmem[mem.v5_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rd_cnt, wr2_cnt, wr6_cnt, first_rd, tim_err, proto_err, last_wr;
    int          done_cnt, done_cyc;
    logic [31:0] tmp_got [8];
    logic [31:0] y_got   [8];

    task automatic clear_mon();
        rd_cnt = 0; wr2_cnt = 0; wr6_cnt = 0; first_rd = -1;
        tim_err = 0; proto_err = 0; last_wr = -1; done_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            tmp_got[k] = 32'hDEAD_BEEF;
            y_got[k]   = 32'hDEAD_BEEF;
        end
    endtask

    always @(negedge clk) begin
        if (mem.v3_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            if (!mem.v4_rd_en || !mem.v5_rd_en || mem.v3_addr != 6'(rd_cnt) ||
                mem.v4_addr != 6'(rd_cnt) || mem.v5_addr != 3'(rd_cnt)) proto_err++;
            rd_cnt++;
        end else if (mem.v4_rd_en || mem.v5_rd_en || mem.v3_addr != 0 ||
                     mem.v4_addr != 0 || mem.v5_addr != 0) proto_err++;
        if (mem.v2_wr_en) begin
            if (mem.v2_addr != 3'(wr2_cnt)) proto_err++;
            if (cyc != first_rd + 9 + 10 * wr2_cnt) tim_err++;
            tmp_got[mem.v2_addr] = mem.v2_wr_data;
            last_wr = cyc;
            wr2_cnt++;
        end else if (mem.v2_addr != 0 || mem.v2_wr_data != 0) proto_err++;
        if (mem.v6_wr_en) begin
            if (mem.v6_addr != 3'(wr6_cnt) || !mem.v2_wr_en) proto_err++;
            y_got[mem.v6_addr] = mem.v6_wr_data;
            wr6_cnt++;
        end else if (mem.v6_addr != 0 || mem.v6_wr_data != 0) proto_err++;
`ifdef GESUMMV_STATUS_EN
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
`endif
    end

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, got, got, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] alpha;
        logic [31:0] beta;
        bit          ovf;
        bit          mid_start;
        logic [31:0] t0;
        logic [31:0] ts;
        logic [31:0] y0;
        logic [31:0] ys;
    } vec_t;

    task automatic load(input bit ovf);
        for (int k = 0; k < 64; k++) begin
            amem[k] = ovf ? 32'h0000_FFFF : 32'(k + 1);
            bmem[k] = amem[k];
        end
        for (int k = 0; k < 8; k++) xmem[k] = ovf ? 32'h0000_FFFF : 32'(k + 1);
    endtask

    task automatic pulse_start();
        tstart = 1'b1;
        @(posedge clk); #1;
        tstart = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        load(v.ovf);
        clear_mon();
        v0 = v.alpha;
        v1 = v.beta;
        pulse_start();
        if (v.mid_start) begin
            repeat (25) @(posedge clk);
            #1;
            pulse_start();
        end
        for (int k = 0; k < 300 && wr2_cnt < 8; k++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s tmp[%0d]", tag, k), tmp_got[k], v.t0 + 32'(k) * v.ts);
            chk($sformatf("%s y[%0d]", tag, k), y_got[k], v.y0 + 32'(k) * v.ys);
        end
        chk({tag, " rd_en cycles"}, 32'(rd_cnt), 32'd64);
        chk({tag, " tmp writes"}, 32'(wr2_cnt), 32'd8);
        chk({tag, " y writes"}, 32'(wr6_cnt), 32'd8);
        chk({tag, " write timing errors"}, 32'(tim_err), 32'd0);
        chk({tag, " protocol errors"}, 32'(proto_err), 32'd0);
`ifdef GESUMMV_STATUS_EN
        chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " done cycle"}, 32'(done_cyc), 32'(last_wr + 1));
        chk({tag, " busy idle"}, {31'd0, busy}, 32'd0);
`endif
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{32'd1, 32'd1, 1'b0, 1'b0, 32'd204, 32'd288, 32'd408, 32'd576};
        vecs[1] = '{32'd2, 32'd3, 1'b0, 1'b0, 32'd204, 32'd288, 32'd1020, 32'd1440};
        vecs[2] = '{32'd1, 32'd1, 1'b0, 1'b1, 32'd204, 32'd288, 32'd408, 32'd576};
        vecs[3] = '{32'd0, 32'd1, 1'b0, 1'b0, 32'd204, 32'd288, 32'd204, 32'd288};
        vecs[4] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd204, 32'd288, 32'd0, 32'd0};
        vecs[5] = '{32'd1, 32'd1, 1'b1, 1'b0, 32'hFFF0_0008, 32'd0, 32'hFFE0_0010, 32'd0};

        rst = 1'b1; tstart = 1'b0; v0 = '0; v1 = '0;
        mem.v3_rd_data = '0; mem.v4_rd_data = '0; mem.v5_rd_data = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rd_en", {29'd0, mem.v3_rd_en, mem.v4_rd_en, mem.v5_rd_en}, 32'd0);
        chk("reset wr_en", {30'd0, mem.v2_wr_en, mem.v6_wr_en}, 32'd0);
        chk("reset addrs", {18'd0, mem.v2_addr, mem.v3_addr, mem.v4_addr, mem.v5_addr}, 32'd0);
        chk("reset v6_addr", {29'd0, mem.v6_addr}, 32'd0);
        chk("reset v2_wr_data", mem.v2_wr_data, 32'd0);
        chk("reset v6_wr_data", mem.v6_wr_data, 32'd0);
`ifdef GESUMMV_STATUS_EN
        chk("reset busy/done", {30'd0, busy, done}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 6; n++) run(vecs[n], $sformatf("vec%0d", n));

        // Mid-run reset while row 3 is being read.
        load(1'b0);
        clear_mon();
        v0 = 32'd1; v1 = 32'd1;
        pulse_start();
        for (int k = 0; k < 200 && wr2_cnt < 3; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst enables", {27'd0, mem.v2_wr_en, mem.v3_rd_en, mem.v4_rd_en,
                               mem.v5_rd_en, mem.v6_wr_en}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst tmp writes", 32'(wr2_cnt), 32'd3);
        chk("midrst y writes", 32'(wr6_cnt), 32'd3);
        chk("midrst rows before reset", tmp_got[2], 32'd780);
        run(vecs[0], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gesummv_engine.md
Name: gesummv_engine

Overview:
- Fixed-size GESUMMV kernel, N=8, 32-bit integers. Computes tmp = A·x and y = alpha·(A·x) + beta·(B·x).
- Reads A, B and x through external 1-cycle-latency read ports (memref_rd style).
- Writes tmp and y through external write ports (memref_wr style).
- Used as an accelerator tile. Started by a one-cycle tstart pulse, driven by the bench clock and start generators.

Parameters:
- N, 8: vector length; matrices are N×N, row-major, flattened (index = i*N+j).
- WIDTH, 32: data width of every port and accumulator.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tstart  in  1  start pulse, sampled only in IDLE.
- v0  in  32  alpha; must stay stable during a run.
- v1  in  32  beta; must stay stable during a run.
- v2_addr  out  3  tmp write address.
- v2_wr_en  out  1  tmp write enable.
- v2_wr_data  out  32  tmp write data.
- v3_addr  out  6  A read address.
- v3_rd_en  out  1  A read enable.
- v3_rd_data  in  32  A read data; valid the cycle after rd_en.
- v4_addr  out  6  B read address.
- v4_rd_en  out  1  B read enable.
- v4_rd_data  in  32  B read data; 1-cycle latency.
- v5_addr  out  3  x read address.
- v5_rd_en  out  1  x read enable.
- v5_rd_data  in  32  x read data; 1-cycle latency.
- v6_addr  out  3  y write address.
- v6_wr_en  out  1  y write enable.
- v6_wr_data  out  32  y write data.

Behaviour:
- Reset:
  - State goes to IDLE; counters i and j go to 0; accumulators ta and ya go to 0.
  - All enables and addresses output 0; all write data outputs 0.
- IDLE:
  - All enables 0.
  - tstart=1 moves to ISSUE with i=0, j=0, and clears ta and ya.
- ISSUE, 8 cycles, j=0..7:
  - v3_rd_en, v4_rd_en and v5_rd_en are all 1.
  - v3_addr = v4_addr = i*8+j; v5_addr = j.
  - From the second ISSUE cycle on, accumulate the data returned for j-1:
    - ta += A·x
    - ya += B·x
  - After j=7, go to ACC.
- ACC, 1 cycle:
  - Read enables are 0.
  - Accumulate the products for j=7.
  - Go to WRITE.
- WRITE, 1 cycle:
  - v2_wr_en = v6_wr_en = 1; v2_addr = v6_addr = i.
  - v2_wr_data = ta.
  - v6_wr_data = alpha·ta + beta·ya.
  - If i=7, go to IDLE. Otherwise i += 1, j = 0, clear ta and ya, and go to ISSUE.
- Timing: each row takes 10 cycles; a full run takes 80 cycles from the first ISSUE cycle.
- Arithmetic:
  - Products and sums are two's-complement, truncated to WIDTH bits (mod 2^32), with no saturation.
  - Multipliers are combinational on rd_data.
- tstart asserted while not in IDLE is ignored; there is no restart mid-run.
- rst mid-run aborts immediately. Writes already performed remain; no further writes occur.
- Outside WRITE, wr_en=0 and write data/addr are driven 0. Outside ISSUE, read addrs are driven 0.
- Exactly one write per output index per run, in ascending order 0..7.

Optional Feature:
- Macro GESUMMV_STATUS_EN.
- When defined, add two outputs:
  - busy (1 bit): 1 in every non-IDLE state.
  - done (1 bit): one-cycle pulse in the cycle after the final WRITE (i=7). Both outputs are reset to 0.
- When undefined, these ports do not exist and the remaining behaviour is identical.

Test Plan:
- Nominal run. Set A[k]=B[k]=k+1 (k=0..63), x[j]=j+1, alpha=beta=1, then pulse tstart.
  - Required: tmp[i]=288i+204, giving tmp[0]=204 and tmp[7]=2220.
  - Required: y[i]=576i+408, giving y[0]=408 and y[7]=4440.
- Scaling. Same data with alpha=2, beta=3.
  - Required: y[i]=5·(288i+204), e.g. y[0]=1020; tmp is unchanged.
- Timing/protocol. Check the following:
  - Read enables are high for exactly 64 cycles.
  - Writes go to addresses 0..7, 10 cycles apart, with the first write 9 cycles after the first ISSUE cycle.
  - No write occurs in any other cycle.
- Ignored start. Pulse tstart again mid-run.
  - Required: results identical to the nominal run; only 8 writes per output.
- Reset mid-run. Assert rst during row 3.
  - Required: all enables are 0 the next cycle, no further writes occur, and a fresh tstart gives correct results.
- Overflow. Set A=B=x=0xFFFF and alpha=beta=1.
  - Required: all outputs match mod-2^32 truncation; with GESUMMV_STATUS_EN, done pulses once.
